// File: rtl/tdc_cal_pkg.sv
// Shared types for the TDC calibration sequencer: FSM states, timeout width, result record.
package tdc_cal_pkg;

  localparam int TO_W      = 8;
  localparam int RES_TAP_W = 8;
  localparam int RES_VAL_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    TRIG,
    WAIT_TDC,
    EMIT,
    DONE
  } state_t;

  // Wide enough for any supported TAP_W/TDC_W; users slice down to their widths.
  typedef struct packed {
    logic [RES_TAP_W-1:0] tap;
    logic [RES_VAL_W-1:0] avg;
    logic [RES_VAL_W-1:0] min;
    logic [RES_VAL_W-1:0] max;
  } cal_res_t;

endpackage

// File: rtl/tdc_cal_if.sv
// Pulse-generator/TDC side plus result valid/ready channel of the calibration sequencer.
interface tdc_cal_if #(
  parameter int TDC_W = 16,
  parameter int TAP_W = 4
) ();

  logic             trig;
  logic             pulse;
  logic [TAP_W-1:0] tap_sel;
  logic             tdc_valid;
  logic [TDC_W-1:0] tdc_value;
  logic             res_valid;
  logic             res_ready;
  logic [TAP_W-1:0] res_tap;
  logic [TDC_W-1:0] res_avg;
  logic [TDC_W-1:0] res_min;
  logic [TDC_W-1:0] res_max;

  modport master (
    output trig, tap_sel, res_valid, res_tap, res_avg, res_min, res_max,
    input  pulse, tdc_valid, tdc_value, res_ready
  );

  modport slave (
    input  trig, tap_sel, res_valid, res_tap, res_avg, res_min, res_max,
    output pulse, tdc_valid, tdc_value, res_ready
  );

endinterface

// File: rtl/tdc_cal_accum.sv
// Per-tap sample accumulator/counter; result one cycle after the last sample, no backpressure.
// Min/max tracking is present only when TDC_CAL_MINMAX_EN is defined.
module tdc_cal_accum
  import tdc_cal_pkg::*;
#(
  parameter int TDC_W    = 16,
  parameter int AVG_LOG2 = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample,
  input  logic [TDC_W-1:0] value,
  output logic [TDC_W-1:0] avg,
  output logic [TDC_W-1:0] min_val,
  output logic [TDC_W-1:0] max_val,
  output logic             last
);

  localparam int ACC_W = TDC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample) begin
      acc <= acc + ACC_W'(value);
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == LAST_CNT);
  assign avg  = TDC_W'(acc >> AVG_LOG2);

`ifdef TDC_CAL_MINMAX_EN
  logic [TDC_W-1:0] min_q;
  logic [TDC_W-1:0] max_q;

  // cnt==0 marks the first sample of a tap, which seeds both registers.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      min_q <= '0;
      max_q <= '0;
    end else if (sample) begin
      if (cnt == '0 || value < min_q) min_q <= value;
      if (cnt == '0 || value > max_q) max_q <= value;
    end
  end

  assign min_val = min_q;
  assign max_val = max_q;
`else
  assign min_val = '0;
  assign max_val = '0;
`endif

endmodule

// File: rtl/tdc_cal_sequencer.sv
// Sweeps tap codes, triggers pulses, averages 2^AVG_LOG2 TDC samples per tap; result held until res_ready.
// TDC_CAL_MINMAX_EN adds per-tap min/max on the result channel.
module tdc_cal_sequencer
  import tdc_cal_pkg::*;
#(
  parameter int TDC_W    = 16,
  parameter int TAP_W    = 4,
  parameter int NUM_TAPS = 16,
  parameter int AVG_LOG2 = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      start,
  tdc_cal_if.master bus,
  output logic      busy,
  output logic      done,
  output logic      err_timeout
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [TAP_W-1:0] tap;
  logic [TO_W-1:0]  to_cnt;
  logic             err;
  logic             acc_clear, acc_sample, last;
  logic             tap_clr, tap_inc, err_set, to_clr;
  logic [TDC_W-1:0] avg, min_val, max_val;
  cal_res_t         res;

  tdc_cal_accum #(.TDC_W(TDC_W), .AVG_LOG2(AVG_LOG2)) u_accum (
    .clk     (clk),
    .reset   (reset),
    .clear   (acc_clear),
    .sample  (acc_sample),
    .value   (bus.tdc_value),
    .avg     (avg),
    .min_val (min_val),
    .max_val (max_val),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    acc_clear  = 1'b0;
    acc_sample = 1'b0;
    tap_clr    = 1'b0;
    tap_inc    = 1'b0;
    err_set    = 1'b0;
    to_clr     = 1'b0;
    case (state)
      IDLE: if (start) begin
        acc_clear = 1'b1;
        tap_clr   = 1'b1;
        state_nxt = GAP;
      end
      GAP: if (!bus.pulse) state_nxt = TRIG;
      TRIG: begin
        to_clr    = 1'b1;
        state_nxt = WAIT_TDC;
      end
      // A sample arriving on the final timeout cycle is still accepted.
      WAIT_TDC: if (bus.tdc_valid) begin
        acc_sample = 1'b1;
        state_nxt  = last ? EMIT : GAP;
      end else if (to_cnt == TO_LAST) begin
        err_set   = 1'b1;
        state_nxt = DONE;
      end
      EMIT: if (bus.res_ready) begin
        if (tap == LAST_TAP) begin
          state_nxt = DONE;
        end else begin
          tap_inc   = 1'b1;
          acc_clear = 1'b1;
          state_nxt = GAP;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tap    <= '0;
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (tap_clr)      tap <= '0;
      else if (tap_inc) tap <= tap + 1'b1;
      if (to_clr)                 to_cnt <= '0;
      else if (state == WAIT_TDC) to_cnt <= to_cnt + 1'b1;
      if (tap_clr)      err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    res = '0;
    if (state == EMIT) begin
      res.tap = RES_TAP_W'(tap);
      res.avg = RES_VAL_W'(avg);
      res.min = RES_VAL_W'(min_val);
      res.max = RES_VAL_W'(max_val);
    end
  end

  assign bus.trig      = (state == TRIG);
  assign bus.tap_sel   = tap;
  assign bus.res_valid = (state == EMIT);
  assign bus.res_tap   = res.tap[TAP_W-1:0];
  assign bus.res_avg   = res.avg[TDC_W-1:0];
  assign bus.res_min   = res.min[TDC_W-1:0];
  assign bus.res_max   = res.max[TDC_W-1:0];
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign err_timeout   = err;

endmodule

// File: tb/tb_tdc_cal_sequencer.sv
// Randomized sweeps against a per-tap sum/min/max model; results scored by a decoupled monitor.
module tb_tdc_cal_sequencer;

  localparam int TDC_W    = 16;
  localparam int TAP_W    = 4;
  localparam int NUM_TAPS = 3;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 8;
  localparam int NS       = 1 << AVG_LOG2;

  typedef struct {
    int tap;
    int avg;
    int mn;
    int mx;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, err_timeout;

  tdc_cal_if #(.TDC_W(TDC_W), .TAP_W(TAP_W)) bus ();

  tdc_cal_sequencer #(
    .TDC_W(TDC_W), .TAP_W(TAP_W), .NUM_TAPS(NUM_TAPS), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus.master),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   done_seen = 0;
  logic done_err = 1'b0;
  int   dir_vals[4] = '{5, 9, 2, 7};

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: result pops, hold-stability, trigger guard, done capture.
  initial begin : monitor
    logic             hold;
    logic [TAP_W-1:0] p_tap;
    logic [TDC_W-1:0] p_avg, p_min, p_max;
    exp_t             e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (hold)
        chk("hold_stable", {bus.res_valid, bus.res_tap == p_tap, bus.res_avg == p_avg,
                            bus.res_min == p_min, bus.res_max == p_max}, 5'b11111);
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got tap %0d avg %0d, expected none", bus.res_tap, bus.res_avg);
        end else begin
          e = sb.pop_front();
          chk("res_tap", bus.res_tap, e.tap);
          chk("res_avg", bus.res_avg, e.avg);
          chk("res_min", bus.res_min, e.mn);
          chk("res_max", bus.res_max, e.mx);
        end
      end
      hold  = bus.res_valid && !bus.res_ready;
      p_tap = bus.res_tap;
      p_avg = bus.res_avg;
      p_min = bus.res_min;
      p_max = bus.res_max;
      if (bus.trig) chk("trig_guard_pulse_or_emit", {bus.pulse, bus.res_valid}, 0);
      if (done) begin
        done_seen++;
        done_err = err_timeout;
      end
    end
  end

  // Consumer with random backpressure, including occasional 5-cycle stalls.
  initial begin : consumer
    bus.res_ready = 1'b0;
    forever begin
      step();
      if ($urandom_range(0, 7) == 0) begin
        bus.res_ready = 1'b0;
        repeat (5) step();
      end else begin
        bus.res_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  task automatic wait_trig(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.trig && n < 400);
    if (!bus.trig) begin
      checks++;
      errors++;
      $display("FAIL trig_wait: no trig within %0d cycles", n);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "trigger never arrived");
    end
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_seen == base && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", done_seen - base, 1);
  endtask

  task automatic quiet_cycles(input string name, input int cycles);
    int act;
    act = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (busy || bus.res_valid || bus.trig) act++;
    end
    chk(name, act, 0);
  endtask

  // mode 0: full sweep; 1: timeout on (at,as); 2: reset during WAIT_TDC of (at,as).
  task automatic run_sweep(input int mode, input int at, input int as, input bit directed);
    int   n, d, ph, m, base, sum, mn, mx;
    int   vals[NS];
    bit   abort;
    exp_t e;
    base  = done_seen;
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("err_cleared_on_start", err_timeout, 0);
    for (int t = 0; t < NUM_TAPS; t++) begin
      for (int s = 0; s < NS; s++)
        vals[s] = (directed && t == 0) ? dir_vals[s % 4] : int'($urandom_range(0, 65535));
      sum = 0;
      mn  = vals[0];
      mx  = vals[0];
      for (int s = 0; s < NS; s++) begin
        sum += vals[s];
        if (vals[s] < mn) mn = vals[s];
        if (vals[s] > mx) mx = vals[s];
      end
      for (int s = 0; s < NS; s++) begin
        wait_trig(n);
        if (t == 0 && s == 0) chk("start_to_trig", n, 1);
        else if (s > 0)       chk("retrig_gap", n, 2);
        chk("tap_sel", bus.tap_sel, t);
        step();
        if (mode == 2 && t == at && s == as) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
          @(negedge clk);
          chk("reset_outputs", {bus.trig, bus.res_valid, busy, done, err_timeout, bus.tap_sel}, 0);
          step();
          bus.tdc_valid = 1'b1;
          bus.tdc_value = 16'h1234;
          step();
          bus.tdc_valid = 1'b0;
          quiet_cycles("late_valid_ignored", 10);
          chk("reset_no_done", done_seen - base, 0);
          chk("reset_sb_empty", sb.size(), 0);
          return;
        end
        abort = (mode == 1 && t == at && s == as);
        d  = abort ? TIMEOUT + 1
                   : (($urandom_range(0, 3) == 0) ? TIMEOUT : int'($urandom_range(1, TIMEOUT)));
        ph = ($urandom_range(0, 3) == 0) ? 12 : int'($urandom_range(0, 4));
        m  = (d > ph) ? d : ph;
        if (s == NS - 1 && !abort) begin
          e.tap = t;
          e.avg = sum >> AVG_LOG2;
`ifdef TDC_CAL_MINMAX_EN
          e.mn = mn;
          e.mx = mx;
`else
          e.mn = 0;
          e.mx = 0;
`endif
          sb.push_back(e);
        end
        for (int k = 1; k <= m; k++) begin
          bus.pulse     = (k <= ph);
          bus.tdc_valid = (k == d);
          bus.tdc_value = (k == d) ? TDC_W'(vals[s]) : TDC_W'($urandom);
          start         = (k < d) && ($urandom_range(0, 3) == 0);
          step();
        end
        bus.pulse     = 1'b0;
        bus.tdc_valid = 1'b0;
        start         = 1'b0;
        if (abort) begin
          wait_done(base);
          chk("timeout_err_at_done", done_err, 1);
          quiet_cycles("abort_quiet", 20);
          chk("err_sticky", err_timeout, 1);
          chk("abort_sb_empty", sb.size(), 0);
          return;
        end
      end
    end
    wait_done(base);
    chk("sweep_no_err", done_err, 0);
    repeat (3) @(negedge clk);
    chk("done_once", done_seen - base, 1);
    chk("busy_after_done", busy, 0);
    chk("sweep_sb_empty", sb.size(), 0);
  endtask

  initial begin : driver
    reset         = 1'b1;
    start         = 1'b0;
    bus.pulse     = 1'b0;
    bus.tdc_valid = 1'b0;
    bus.tdc_value = '0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_state", {bus.trig, bus.res_valid, busy, done, err_timeout, bus.tap_sel,
                        bus.res_tap, bus.res_avg, bus.res_min, bus.res_max}, 0);
    step();
    reset = 1'b0;
    step();
    run_sweep(0, 0, 0, 1'b1);
    run_sweep(2, 1, 1, 1'b0);
    run_sweep(0, 0, 0, 1'b0);
    run_sweep(1, 1, 2, 1'b0);
    run_sweep(0, 0, 0, 1'b0);
    run_sweep(1, 0, 0, 1'b0);
    run_sweep(0, 0, 0, 1'b0);
    run_sweep(0, 0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
